// File: rtl/alu_pkg.sv
// Shared definitions for the ALU datapath blocks: operand width, multiply
// step count and the multiplier's state encoding.
package alu_pkg;

    localparam int WIDTH = 16;
    localparam int STEPS = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/adder.sv
// 16-bit ripple-carry adder; overflow is the carry out of the top bit.
module adder
    import alu_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             overflow
);

    always_comb begin
        logic carry;
        carry = 1'b0;
        sum   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        overflow = carry;
    end

endmodule

// File: rtl/mult_shift_add.sv
// Sequential unsigned 16x16 shift-and-add multiplier with valid/ready on both
// sides; one partial-product step per cycle through the shared ripple adder.
module mult_shift_add
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product
);

    // The adder is hard-wired to 16 bits, so any other width cannot work.
    if (WIDTH != alu_pkg::WIDTH) begin : g_bad_width
        $error("mult_shift_add: WIDTH must be 16");
    end
    if ((1 << CNT_W) <= WIDTH) begin : g_bad_cnt_w
        $error("mult_shift_add: CNT_W too narrow for WIDTH steps");
    end

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic               carry;

    assign addend  = q_q[0] ? m_q : '0;
    assign product = {acc_q, q_q};

    adder u_adder (
        .a        (acc_q),
        .b        (addend),
        .sum      (sum),
        .overflow (carry)
    );

    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        acc_d     = acc_q;
        q_d       = q_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    m_d     = a;
                    q_d     = b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // The carry lands in ACC's MSB, so the full 32-bit product is kept.
                {acc_d, q_d} = {carry, sum, q_q[WIDTH-1:1]};
                cnt_d        = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(STEPS - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            m_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mult_shift_add.sv
// Self-checking bench for mult_shift_add: directed cases plus random operand
// pairs compared against plain a*b, including latency and handshake timing.
module tb_mult_shift_add;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] product;

    int assert_count = 0;
    int fail_count   = 0;

    always #5 clk = ~clk;

    mult_shift_add #(
        .WIDTH (16),
        .CNT_W (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges after the accepting edge until out_valid rises; 0 means timeout.
    task automatic waitResult(input string tag, output int latency);
        latency = 0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (out_valid === 1'b1) begin
                latency = k;
                break;
            end
        end
        checkOutput($sformatf("%s latency", tag), 32'(latency), 32'd16);
    endtask

    // One full transaction: accept, 16 steps, optional backpressure, handoff.
    task automatic applyStimulus(input string tag, input logic [15:0] op_a,
                                 input logic [15:0] op_b, input int hold);
        logic [31:0] expected;
        int          lat;
        expected = 32'(op_a) * 32'(op_b);
        checkOutput($sformatf("%s in_ready idle", tag), 32'(in_ready), 32'd1);
        a         = op_a;
        b         = op_b;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        tick();
        in_valid = 1'b0;
        a        = 16'($urandom);
        b        = 16'($urandom);
        checkOutput($sformatf("%s in_ready busy", tag), 32'(in_ready), 32'd0);
        checkOutput($sformatf("%s out_valid busy", tag), 32'(out_valid), 32'd0);
        waitResult(tag, lat);
        checkOutput($sformatf("%s product", tag), product, expected);
        for (int i = 0; i < hold; i++) begin
            tick();
            checkOutput($sformatf("%s held out_valid", tag), 32'(out_valid), 32'd1);
            checkOutput($sformatf("%s held product", tag), product, expected);
        end
        out_ready = 1'b1;
        tick();
        checkOutput($sformatf("%s out_valid after handoff", tag), 32'(out_valid), 32'd0);
        checkOutput($sformatf("%s in_ready after handoff", tag), 32'(in_ready), 32'd1);
    endtask

    initial begin
        int          lat;
        logic        saw_valid;
        logic [15:0] ra;
        logic [15:0] rb;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        repeat (2) tick();
        rst = 1'b0;
        checkOutput("reset in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset product", product, 32'd0);

        applyStimulus("3x5", 16'd3, 16'd5, 0);
        applyStimulus("ffff x ffff", 16'hFFFF, 16'hFFFF, 0);
        applyStimulus("1234 x 0", 16'h1234, 16'h0000, 0);
        applyStimulus("0 x beef", 16'h0000, 16'hBEEF, 0);
        applyStimulus("8000 x 2 stall", 16'h8000, 16'h0002, 5);

        // in_valid held through BUSY with new operands; only the first pair counts.
        a         = 16'd7;
        b         = 16'd9;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        tick();
        a = 16'd10;
        b = 16'd10;
        checkOutput("held in_valid in_ready busy", 32'(in_ready), 32'd0);
        waitResult("7x9", lat);
        checkOutput("7x9 product", product, 32'd63);
        out_ready = 1'b1;
        tick();
        checkOutput("7x9 out_valid after handoff", 32'(out_valid), 32'd0);
        checkOutput("7x9 in_ready after handoff", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        checkOutput("10x10 in_ready busy", 32'(in_ready), 32'd0);
        waitResult("10x10", lat);
        checkOutput("10x10 product", product, 32'd100);
        tick();
        checkOutput("10x10 out_valid after handoff", 32'(out_valid), 32'd0);

        // Reset partway through a multiply discards the computation.
        a         = 16'hABCD;
        b         = 16'h1357;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (8) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("mid reset in_ready", 32'(in_ready), 32'd1);
        checkOutput("mid reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("mid reset product", product, 32'd0);
        saw_valid = 1'b0;
        repeat (20) begin
            tick();
            if (out_valid !== 1'b0) saw_valid = 1'b1;
        end
        checkOutput("mid reset no out_valid", 32'(saw_valid), 32'd0);
        applyStimulus("2x2 after reset", 16'd2, 16'd2, 0);

        for (int i = 0; i < 8; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            applyStimulus($sformatf("random %0d", i), ra, rb, int'($urandom_range(0, 3)));
        end

        $display("[TB] End of test - %0d assertions evaluated, %0d failures",
                 assert_count, fail_count);
        $finish;
    end

endmodule
